// File: rtl/chacha_block_sequencer_if.sv
// Handshake bundle between the ChaCha block sequencer, its word streams and the external QR core.
`timescale 1ns/1ps
interface chacha_block_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        qr_start;
    logic [31:0] qr_a;
    logic [31:0] qr_b;
    logic [31:0] qr_c;
    logic [31:0] qr_d;
    logic        qr_done;
    logic [31:0] qr_ra;
    logic [31:0] qr_rb;
    logic [31:0] qr_rc;
    logic [31:0] qr_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    // The sequencer side; the environment (word source/sink and QR core) takes the mirror image.
    modport slave (
        input  in_valid, in_data, qr_done, qr_ra, qr_rb, qr_rc, qr_rd, out_ready,
        output in_ready, qr_start, qr_a, qr_b, qr_c, qr_d, out_valid, out_data, out_last, busy
    );

    modport master (
        output in_valid, in_data, qr_done, qr_ra, qr_rb, qr_rc, qr_rd, out_ready,
        input  in_ready, qr_start, qr_a, qr_b, qr_c, qr_d, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/chacha_block_sequencer.sv
// Holds the 16-word ChaCha state, sequences an external quarter-round core through all double
// rounds, then streams out working state plus original state as keystream words.
`timescale 1ns/1ps
module chacha_block_sequencer #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input logic                      clk,
    input logic                      rst_n,
    chacha_block_sequencer_if.slave  bus_if
);

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, OUT} state_t;

    localparam logic [3:0] LAST_RND = 4'(DOUBLE_ROUNDS - 1);

    state_t      state_q;
    logic [31:0] w_q [16];
    logic [31:0] s_q [16];
    logic [31:0] w_d [16];
    logic [31:0] s_d [16];
    logic [3:0]  ld_cnt_q;
    logic [3:0]  out_cnt_q;
    logic [3:0]  rnd_q;
    logic [2:0]  qr_idx_q;
    logic        in_ready_q;
    logic        qr_start_q;
    logic [31:0] qr_a_q;
    logic [31:0] qr_b_q;
    logic [31:0] qr_c_q;
    logic [31:0] qr_d_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        out_last_q;
    logic        busy_q;

    logic        load_fire;
    logic        qr_fire;
    logic        out_fire;
    logic [2:0]  issue_idx_d;
    logic [3:0]  out_idx_d;

    // Column QRs use row offset 0; diagonal QRs rotate each row by its position.
    function automatic logic [3:0] sched(input logic [2:0] idx, input logic [1:0] pos);
        logic [1:0] col;
        col = idx[1:0] + (idx[2] ? pos : 2'd0);
        return {pos, col};
    endfunction

    assign load_fire   = (state_q == LOAD)  && bus_if.in_valid;
    assign qr_fire     = (state_q == WAIT)  && bus_if.qr_done;
    assign out_fire    = (state_q == OUT)   && bus_if.out_ready;
    assign issue_idx_d = (state_q == LOAD) ? 3'd0 : qr_idx_q + 3'd1;
    assign out_idx_d   = out_cnt_q + 4'd1;

    // Next-state view of the storage; operands and output words are read from it so that
    // a QR issued right after a write-back already sees the fresh results.
    always_comb begin
        w_d = w_q;
        s_d = s_q;
        if (load_fire) begin
            w_d[ld_cnt_q] = bus_if.in_data;
            s_d[ld_cnt_q] = bus_if.in_data;
        end
        if (qr_fire) begin
            w_d[sched(qr_idx_q, 2'd0)] = bus_if.qr_ra;
            w_d[sched(qr_idx_q, 2'd1)] = bus_if.qr_rb;
            w_d[sched(qr_idx_q, 2'd2)] = bus_if.qr_rc;
            w_d[sched(qr_idx_q, 2'd3)] = bus_if.qr_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
                s_q[i] <= '0;
            end
            ld_cnt_q    <= '0;
            out_cnt_q   <= '0;
            rnd_q       <= '0;
            qr_idx_q    <= '0;
            in_ready_q  <= 1'b1;
            qr_start_q  <= 1'b0;
            qr_a_q      <= '0;
            qr_b_q      <= '0;
            qr_c_q      <= '0;
            qr_d_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            w_q <= w_d;
            s_q <= s_d;
            case (state_q)
                LOAD: begin
                    if (load_fire) begin
                        if (ld_cnt_q == 4'd15) begin
                            ld_cnt_q   <= '0;
                            qr_idx_q   <= '0;
                            rnd_q      <= '0;
                            state_q    <= ISSUE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            qr_start_q <= 1'b1;
                            qr_a_q     <= w_d[sched(issue_idx_d, 2'd0)];
                            qr_b_q     <= w_d[sched(issue_idx_d, 2'd1)];
                            qr_c_q     <= w_d[sched(issue_idx_d, 2'd2)];
                            qr_d_q     <= w_d[sched(issue_idx_d, 2'd3)];
                        end else begin
                            ld_cnt_q <= ld_cnt_q + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    qr_start_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (qr_fire) begin
                        qr_idx_q <= issue_idx_d;
                        if (qr_idx_q != 3'd7 || rnd_q != LAST_RND) begin
                            if (qr_idx_q == 3'd7) begin
                                rnd_q <= rnd_q + 4'd1;
                            end
                            state_q    <= ISSUE;
                            qr_start_q <= 1'b1;
                            qr_a_q     <= w_d[sched(issue_idx_d, 2'd0)];
                            qr_b_q     <= w_d[sched(issue_idx_d, 2'd1)];
                            qr_c_q     <= w_d[sched(issue_idx_d, 2'd2)];
                            qr_d_q     <= w_d[sched(issue_idx_d, 2'd3)];
                        end else begin
                            out_cnt_q   <= '0;
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= w_d[0] + s_d[0];
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        if (out_cnt_q == 4'd15) begin
                            out_cnt_q   <= '0;
                            state_q     <= LOAD;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            out_cnt_q  <= out_idx_d;
                            out_data_q <= w_d[out_idx_d] + s_d[out_idx_d];
                            out_last_q <= (out_idx_d == 4'd15);
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign bus_if.in_ready  = in_ready_q;
    assign bus_if.qr_start  = qr_start_q;
    assign bus_if.qr_a      = qr_a_q;
    assign bus_if.qr_b      = qr_b_q;
    assign bus_if.qr_c      = qr_c_q;
    assign bus_if.qr_d      = qr_d_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_data_q;
    assign bus_if.out_last  = out_last_q;
    assign bus_if.busy      = busy_q;

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Bench for chacha_block_sequencer: ChaCha20 and ChaCha8 instances, QR core models and a
// reference ChaCha block function.
`timescale 1ns/1ps
module tb_chacha_block_sequencer;

    typedef logic [15:0][31:0] block_t;

    typedef struct {
        block_t inWords;
        block_t expWords;
        int     latMin;
        int     latMax;
        bit     backpressure;
        bit     checkLatency;
    } vector_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sel;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;

    chacha_block_sequencer_if bus20();
    chacha_block_sequencer_if bus8();

    chacha_block_sequencer #(.DOUBLE_ROUNDS(10)) dut20 (.clk(clk), .rst_n(rst_n), .bus_if(bus20));
    chacha_block_sequencer #(.DOUBLE_ROUNDS(4))  dut8  (.clk(clk), .rst_n(rst_n), .bus_if(bus8));

    // sel picks which instance the word source/sink talks to; the other one sees idle inputs.
    assign bus20.in_valid  = inValid & ~sel;
    assign bus8.in_valid   = inValid & sel;
    assign bus20.in_data   = inData;
    assign bus8.in_data    = inData;
    assign bus20.out_ready = outReady & ~sel;
    assign bus8.out_ready  = outReady & sel;

    logic        inReady;
    logic        outValid;
    logic        outLast;
    logic        busyMux;
    logic        qrStartMux;
    logic [31:0] outData;
    assign inReady    = sel ? bus8.in_ready  : bus20.in_ready;
    assign outValid   = sel ? bus8.out_valid : bus20.out_valid;
    assign outLast    = sel ? bus8.out_last  : bus20.out_last;
    assign outData    = sel ? bus8.out_data  : bus20.out_data;
    assign busyMux    = sel ? bus8.busy      : bus20.busy;
    assign qrStartMux = sel ? bus8.qr_start  : bus20.qr_start;

    int     testsRun = 0;
    int     failures = 0;
    int     schedTab [8][4];
    int     qrLatMin = 1;
    int     qrLatMax = 1;
    int     qrStarts = 0;
    int     qrStarts8 = 0;
    int     qrSeq = 0;
    bit     qrAbort = 1'b0;
    block_t tbW;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarterRound(input logic [127:0] v);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = v;
        a = a + b; d = d ^ a; d = rotl(d, 16);
        c = c + d; b = b ^ c; b = rotl(b, 12);
        a = a + b; d = d ^ a; d = rotl(d, 8);
        c = c + d; b = b ^ c; b = rotl(b, 7);
        return {a, b, c, d};
    endfunction

    function automatic block_t applyQr(input block_t x, input int ia, input int ib, input int ic, input int id);
        logic [127:0] r;
        r = quarterRound({x[ia], x[ib], x[ic], x[id]});
        x[ia] = r[127:96];
        x[ib] = r[95:64];
        x[ic] = r[63:32];
        x[id] = r[31:0];
        return x;
    endfunction

    function automatic block_t chachaRef(input block_t s, input int dr);
        block_t x;
        block_t y;
        x = s;
        for (int r = 0; r < dr; r++) begin
            for (int i = 0; i < 4; i++) x = applyQr(x, i, 4 + i, 8 + i, 12 + i);
            for (int i = 0; i < 4; i++) x = applyQr(x, i, 4 + (i + 1) % 4, 8 + (i + 2) % 4, 12 + (i + 3) % 4);
        end
        for (int i = 0; i < 16; i++) y[i] = x[i] + s[i];
        return y;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        testsRun++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Models a QR core for the ChaCha20 instance and checks every issued operand set
    // against a mirror of the working state driven by the schedule table.
    task automatic serveQr();
        logic [127:0] ops, expOps, res, mirror;
        int k, lat;
        ops    = {bus20.qr_a, bus20.qr_b, bus20.qr_c, bus20.qr_d};
        k      = qrSeq % 8;
        expOps = {tbW[schedTab[k][0]], tbW[schedTab[k][1]], tbW[schedTab[k][2]], tbW[schedTab[k][3]]};
        checkOutput($sformatf("qr %0d operands", qrSeq), ops, expOps);
        mirror = quarterRound(expOps);
        tbW[schedTab[k][0]] = mirror[127:96];
        tbW[schedTab[k][1]] = mirror[95:64];
        tbW[schedTab[k][2]] = mirror[63:32];
        tbW[schedTab[k][3]] = mirror[31:0];
        qrSeq++;
        qrStarts++;
        res = quarterRound(ops);
        lat = int'($urandom_range(qrLatMax, qrLatMin));
        for (int c = 0; c < lat; c++) begin
            tick();
            if (!qrAbort) begin
                if (c == 0) checkOutput("qr_start one-cycle pulse", 128'(bus20.qr_start), 128'(0));
                checkOutput("qr operands held", {bus20.qr_a, bus20.qr_b, bus20.qr_c, bus20.qr_d}, ops);
            end
        end
        bus20.qr_done = 1'b1;
        {bus20.qr_ra, bus20.qr_rb, bus20.qr_rc, bus20.qr_rd} = res;
        tick();
        bus20.qr_done = 1'b0;
    endtask

    initial begin
        bus20.qr_done = 1'b0;
        {bus20.qr_ra, bus20.qr_rb, bus20.qr_rc, bus20.qr_rd} = '0;
        forever begin
            if (bus20.qr_start === 1'b1) serveQr();
            else tick();
        end
    end

    initial begin
        logic [127:0] r;
        bus8.qr_done = 1'b0;
        {bus8.qr_ra, bus8.qr_rb, bus8.qr_rc, bus8.qr_rd} = '0;
        forever begin
            if (bus8.qr_start === 1'b1) begin
                qrStarts8++;
                r = quarterRound({bus8.qr_a, bus8.qr_b, bus8.qr_c, bus8.qr_d});
                tick();
                bus8.qr_done = 1'b1;
                {bus8.qr_ra, bus8.qr_rb, bus8.qr_rc, bus8.qr_rd} = r;
                tick();
                bus8.qr_done = 1'b0;
            end else begin
                tick();
            end
        end
    end

    task automatic applyStimulus(input block_t words);
        int waited;
        for (int i = 0; i < 16; i++) begin
            inValid = 1'b1;
            inData  = words[i];
            waited  = 0;
            while (!inReady && waited < 1000) begin
                tick();
                waited++;
            end
            if (!inReady) timeoutFail($sformatf("in_ready for word %0d", i));
            tick();
        end
        inValid = 1'b0;
    endtask

    task automatic waitOutValid(output int cycles);
        cycles = 0;
        while (!outValid && cycles < 20000) begin
            tick();
            cycles++;
        end
        if (!outValid) timeoutFail("first out_valid");
    endtask

    task automatic readBlock(input block_t expWords, input bit bp);
        int stall, waited;
        outReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            waited = 0;
            while (!outValid && waited < 1000) begin
                tick();
                waited++;
            end
            stall = 0;
            if (bp) stall = (i == 3) ? 7 : ((i > 3 && i % 2 == 0) ? 1 : 0);
            if (stall > 0) begin
                outReady = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    checkOutput($sformatf("stalled word %0d", i),
                                128'({outValid, outLast, outData}), 128'({1'b1, i == 15, expWords[i]}));
                end
                outReady = 1'b1;
            end
            checkOutput($sformatf("word %0d valid/last/data", i),
                        128'({outValid, outLast, outData}), 128'({1'b1, i == 15, expWords[i]}));
            tick();
        end
        outReady = 1'b0;
    endtask

    task automatic runVector(input vector_t v, input int dr);
        int cycles;
        qrLatMin  = v.latMin;
        qrLatMax  = v.latMax;
        qrStarts  = 0;
        qrStarts8 = 0;
        qrSeq     = 0;
        tbW       = v.inWords;
        qrAbort   = 1'b0;
        checkOutput("in_ready before load", 128'(inReady), 128'(1));
        applyStimulus(v.inWords);
        checkOutput("busy after load", 128'({busyMux, inReady}), 128'(2'b10));
        waitOutValid(cycles);
        if (v.checkLatency) checkOutput("first out_valid latency", 128'(cycles), 128'(16 * dr));
        readBlock(v.expWords, v.backpressure);
        checkOutput("qr_start pulse count", 128'(sel ? qrStarts8 : qrStarts), 128'(8 * dr));
        checkOutput("idle after block", 128'({inReady, busyMux, outValid}), 128'(3'b100));
    endtask

    logic [31:0] rfcInList  [16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                                     32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                     32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                                     32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    logic [31:0] rfcOutList [16] = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                                     32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                                     32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                                     32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    vector_t vectors [5];

    initial begin
        block_t rfcIn, rfcOut, rnd;
        vector_t v;
        int startsAtReset, waited;

        schedTab = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                     '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        for (int i = 0; i < 16; i++) begin
            rfcIn[i]  = rfcInList[i];
            rfcOut[i] = rfcOutList[i];
            rnd[i]    = $urandom;
        end
        vectors[0] = '{inWords: '0,    expWords: '0,                 latMin: 1, latMax: 1, backpressure: 1'b0, checkLatency: 1'b1};
        vectors[1] = '{inWords: rfcIn, expWords: rfcOut,             latMin: 1, latMax: 1, backpressure: 1'b0, checkLatency: 1'b1};
        vectors[2] = '{inWords: rfcIn, expWords: rfcOut,             latMin: 1, latMax: 5, backpressure: 1'b0, checkLatency: 1'b0};
        vectors[3] = '{inWords: rfcIn, expWords: rfcOut,             latMin: 1, latMax: 1, backpressure: 1'b1, checkLatency: 1'b1};
        vectors[4] = '{inWords: rnd,   expWords: chachaRef(rnd, 10), latMin: 1, latMax: 5, backpressure: 1'b1, checkLatency: 1'b0};

        sel      = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        rst_n    = 1'b0;
        repeat (3) tick();
        checkOutput("reset handshake outputs", 128'({bus20.in_ready, bus20.qr_start, bus20.out_valid, bus20.out_last, bus20.busy}),
                    128'(5'b10000));
        checkOutput("reset qr operands", {bus20.qr_a, bus20.qr_b, bus20.qr_c, bus20.qr_d}, 128'(0));
        checkOutput("reset out_data", 128'(bus20.out_data), 128'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) runVector(vectors[i], 10);

        // Reset during a long QR wait in round 5, with the QR result arriving after reset.
        qrLatMin = 6;
        qrLatMax = 6;
        qrStarts = 0;
        qrSeq    = 0;
        tbW      = rfcIn;
        applyStimulus(rfcIn);
        waited = 0;
        while (qrStarts < 41 && waited < 5000) begin
            tick();
            waited++;
        end
        if (qrStarts < 41) timeoutFail("round 5 qr_start");
        qrAbort = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        startsAtReset = qrStarts;
        checkOutput("mid-run reset state", 128'({inReady, busyMux, outValid, qrStartMux}), 128'(4'b1000));
        repeat (10) tick();
        checkOutput("late qr_done ignored", 128'({inReady, busyMux, outValid}), 128'(3'b100));
        checkOutput("no qr_start after reset", 128'(qrStarts), 128'(startsAtReset));
        runVector(vectors[0], 10);

        sel = 1'b1;
        tick();
        v = '{inWords: rfcIn, expWords: chachaRef(rfcIn, 4), latMin: 1, latMax: 1, backpressure: 1'b0, checkLatency: 1'b1};
        runVector(v, 4);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
